// File: rtl/alu_li_arbiter.sv
// Round-robin arbiter sharing one latency-insensitive ALU between N_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, result routed back to its owner.
module alu_li_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int N_REQ = 4,
    parameter  int CNT_W = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_op,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]       resp_result,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic                   alu_op,
    output logic                   alu_valid,
    input  logic                   alu_ready,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_done,
    output logic                   alu_ack,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [CNT_W-1:0]       txn_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, winner, grant_q;
    logic [ID_W:0]     sum;
    logic              found, accept, resp_hs;
    logic [WIDTH-1:0]  a_q, b_q, result_q, sel_a, sel_b;
    logic              op_q, sel_op;
    logic [CNT_W-1:0]  cnt_q;

    // First pending request at or above ptr, wrapping past N_REQ-1
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i];
            end
        end
    end

    assign accept  = (state == IDLE) && found;
    assign resp_hs = (state == RESP) && resp_ready[grant_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        alu_valid  = 1'b0;
        alu_ack    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by reset so every output reads 0 while reset is held
                if (accept && reset) begin
                    req_ready = N_REQ'(1) << winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                alu_valid = 1'b1;
                if (alu_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                alu_ack = 1'b1;
                if (alu_done)
                    state_nxt = RESP;
            end
            RESP: begin
                resp_valid = N_REQ'(1) << grant_q;
                if (resp_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                op_q    <= sel_op;
                grant_q <= winner;
                ptr     <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
            end
            if (state == WAIT && alu_done)
                result_q <= alu_result;
            if (resp_hs)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign resp_result = result_q;
    assign grant_id    = grant_q;
    assign txn_count   = cnt_q;

endmodule
